// File: rtl/jtl_sched_pkg.sv
// rtl/jtl_sched_pkg.sv - shared types, widths and helpers for the JTL pulse scheduler
package jtl_sched_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } sched_state_t;

    localparam int LAUNCH_CNT_W = 16;

    // Bits needed to hold a count of ct-1 down to 0; never less than one bit.
    function automatic int hold_cnt_w(input int ct);
        return (ct <= 1) ? 1 : $clog2(ct);
    endfunction

endpackage

// File: rtl/jtl_pulse_sched_rr_arbiter.sv
// rtl/jtl_pulse_sched_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [PTR_W-1:0] win_idx,
    output logic             win_valid
);

    // Scan upward from the pointer, wrapping, and keep the first set request.
    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        win_valid  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = (int'(ptr) + i) % N_REQ;
            if (!win_valid && req[idx]) begin
                win_valid       = 1'b1;
                win_idx         = PTR_W'(idx);
                win_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtl_pulse_sched.sv
// rtl/jtl_pulse_sched.sv - shares one JTL toggle line with a hold-off window; optional JTL_SCHED_ARRIVAL_EN adds arrival pulses
module jtl_pulse_sched
    import jtl_sched_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int CT_CYCLES    = 10,
    parameter int DELAY_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic                    bias_ok,
    output logic [N_REQ-1:0]        gnt,
    output logic                    drv,
    output logic                    busy,
    output logic [LAUNCH_CNT_W-1:0] launch_cnt,
    output logic                    done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = hold_cnt_w(CT_CYCLES);

    if (N_REQ < 2) begin : g_bad_n_req
        $fatal(1, "jtl_pulse_sched: N_REQ must be >= 2");
    end
    if (CT_CYCLES < 1) begin : g_bad_ct
        $fatal(1, "jtl_pulse_sched: CT_CYCLES must be >= 1");
    end
    if (DELAY_CYCLES < 1) begin : g_bad_delay
        $fatal(1, "jtl_pulse_sched: DELAY_CYCLES must be >= 1");
    end

    sched_state_t            r_state;
    logic [PTR_W-1:0]        r_ptr;
    logic [CNT_W-1:0]        r_hold;
    logic [N_REQ-1:0]        r_gnt;
    logic                    r_drv;
    logic                    r_busy;
    logic [LAUNCH_CNT_W-1:0] r_cnt;

    logic [N_REQ-1:0]        w_win_onehot;
    logic [PTR_W-1:0]        w_win_idx;
    logic                    w_win_valid;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req        (req),
        .ptr        (r_ptr),
        .win_onehot (w_win_onehot),
        .win_idx    (w_win_idx),
        .win_valid  (w_win_valid)
    );

    // Launch/hold-off sequencer: one toggle per win, then CT_CYCLES of HOLD before re-arbitrating.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_gnt   <= '0;
            r_drv   <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_gnt <= '0;
                    if (bias_ok && w_win_valid) begin
                        r_gnt   <= w_win_onehot;
                        r_drv   <= ~r_drv;
                        r_cnt   <= r_cnt + 1'b1;
                        r_ptr   <= (w_win_idx == PTR_W'(N_REQ - 1)) ? '0 : w_win_idx + PTR_W'(1);
                        r_hold  <= CNT_W'(CT_CYCLES - 1);
                        r_busy  <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    r_gnt <= '0;
                    if (r_hold == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign drv        = r_drv;
    assign busy       = r_busy;
    assign launch_cnt = r_cnt;

`ifdef JTL_SCHED_ARRIVAL_EN
    logic                    w_launch;
    logic [DELAY_CYCLES-1:0] r_flight;
    logic                    r_done;

    assign w_launch = (r_state == IDLE) && bias_ok && w_win_valid;

    // Flight line: a launch enters with the drv toggle and emerges as done DELAY_CYCLES later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flight <= '0;
            r_done   <= 1'b0;
        end else begin
            r_flight <= (r_flight << 1) | DELAY_CYCLES'(w_launch);
            r_done   <= r_flight[DELAY_CYCLES-1];
        end
    end

    assign done = r_done;
`else
    assign done = 1'b0;
`endif

endmodule
